// File: rtl/riscv_fetch_pkg.sv
// Shared fetch definitions: reset PC default, PC step, instruction width and
// the {pc, inst} entry type carried through the instruction buffer.
package riscv_defs;

   localparam int          INST_W           = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] PC_INC           = 32'd4;

   typedef struct packed {
      logic [31:0]       pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

   // 32-bit add wraps 32'hFFFF_FFFC -> 32'h0000_0000 naturally.
   function automatic logic [31:0] pc_next(input logic [31:0] pc);
      return pc + PC_INC;
   endfunction

   function automatic logic [31:0] pc_align(input logic [31:0] pc);
      return pc & ~32'h3;
   endfunction

endpackage

// File: rtl/riscv_fetch_if.sv
// Fetch unit bus: memory request/response, redirect and decoder handoff.
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; imem_rsp_valid has no ready and is in request order.
interface riscv_fetch_if;
   import riscv_defs::*;

   logic                imem_req_valid;
   logic [31:0]         imem_req_addr;
   logic                imem_req_ready;
   logic                imem_rsp_valid;
   logic [INST_W-1:0]   imem_rsp_data;
   logic                redirect_valid;
   logic [31:0]         redirect_pc;
   logic                inst_valid;
   logic [INST_W-1:0]   inst;
   logic [31:0]         inst_pc;
   logic                inst_ready;

   modport master (
      output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
             redirect_valid, redirect_pc, inst_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
             redirect_valid, redirect_pc, inst_ready
   );

endinterface

// File: rtl/riscv_fetch_fifo.sv
// Instruction buffer: DEPTH entries of {pc, inst}; flush empties it in one cycle.
module riscv_fetch_fifo
   import riscv_defs::*;
#(
   parameter  int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  fetch_entry_t     push_entry,
   input  logic             pop,
   input  logic             flush,
   output fetch_entry_t     head,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty && !flush && !rst;
   // A pop frees the slot in the same cycle, so push into a full buffer is fine then.
   assign do_push = push && (!full || do_pop) && !flush && !rst;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= bump(wr_ptr);
         if (do_pop)  rd_ptr <= bump(rd_ptr);
         if (do_push && !do_pop)      count <= count + CNT_W'(1);
         else if (!do_push && do_pop) count <= count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_entry;
   end

   overflow_never : assert property (@(posedge clk) disable iff (rst || flush)
      !(push && full && !(pop && !empty)))
      else $error("riscv_fetch_fifo overflow");

endmodule

// File: rtl/riscv_fetch.sv
// Instruction fetch: credit-limited request stream, in-order responses into a
// small buffer, redirect flush with a drop counter for stale responses.
module riscv_fetch
   import riscv_defs::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          DEPTH    = 2
) (
   input logic         clk,
   input logic         rst,
   riscv_fetch_if.master bus
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int SUM_W = CNT_W + 1;

   logic [31:0]      fetch_pc;
   logic [31:0]      rsp_pc;
   logic [CNT_W-1:0] outstanding;
   logic [CNT_W-1:0] out_next;
   logic [CNT_W-1:0] drop_cnt;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_empty;
   logic             credit_ok;
   logic             req_fire;
   logic             rsp_take;
   logic             push;
   logic             pop;
   logic [31:0]      redirect_target;
   fetch_entry_t     head;
   fetch_entry_t     push_entry;

   // Credits cover both in-flight requests and buffered words, so a push never overflows.
   assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_count}) < SUM_W'(DEPTH);

   assign bus.imem_req_valid = !rst && !bus.redirect_valid && credit_ok;
   assign bus.imem_req_addr  = rst ? pc_align(RESET_PC) : fetch_pc;

   assign req_fire        = bus.imem_req_valid && bus.imem_req_ready;
   assign rsp_take        = bus.imem_rsp_valid && (outstanding != '0) && !rst;
   assign push            = rsp_take && (drop_cnt == '0) && !bus.redirect_valid;
   assign pop             = bus.inst_valid && bus.inst_ready;
   assign redirect_target = pc_align(bus.redirect_pc);

   assign push_entry.pc   = rsp_pc;
   assign push_entry.inst = bus.imem_rsp_data;

   assign bus.inst_valid = !rst && !fifo_empty && !bus.redirect_valid;
   assign bus.inst       = rst ? '0 : head.inst;
   assign bus.inst_pc    = rst ? '0 : head.pc;

   always_comb begin
      out_next = outstanding;
      if (req_fire && !rsp_take)      out_next = outstanding + CNT_W'(1);
      else if (!req_fire && rsp_take) out_next = outstanding - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc    <= pc_align(RESET_PC);
         rsp_pc      <= pc_align(RESET_PC);
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         outstanding <= out_next;
         if (bus.redirect_valid) begin
            // Everything still in flight belongs to the old stream; replace, never add.
            fetch_pc <= redirect_target;
            rsp_pc   <= redirect_target;
            drop_cnt <= out_next;
         end else begin
            if (req_fire) fetch_pc <= pc_next(fetch_pc);
            if (push)     rsp_pc   <= pc_next(rsp_pc);
            if (rsp_take && (drop_cnt != '0)) drop_cnt <= drop_cnt - CNT_W'(1);
         end
      end
   end

   riscv_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .flush      (bus.redirect_valid),
      .head       (head),
      .empty      (fifo_empty),
      .count      (fifo_count)
   );

endmodule

// File: tb/tb_riscv_fetch.sv
// Directed bench for riscv_fetch with a latency-configurable in-order memory model.
module tb_riscv_fetch;
   import riscv_defs::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   riscv_fetch_if bus ();

   riscv_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   mreq_t       mq[$];
   logic [31:0] hs_q[$];
   logic [31:0] xpc_q[$];
   logic [31:0] xinst_q[$];

   int          n_vec  = 0;
   int          n_miss = 0;
   int          cyc    = 0;
   int          lat    = 1;
   logic        samp_req_valid;
   logic        samp_req_ready;
   logic [31:0] samp_req_addr;
   logic        samp_inst_valid;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
      return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
   endfunction

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic clear_logs();
      hs_q.delete();
      xpc_q.delete();
      xinst_q.delete();
   endtask

   // One clock cycle: drive the memory response, sample, record handshakes, advance.
   task automatic step();
      if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data  = mem_word(mq[0].addr);
      end else begin
         bus.imem_rsp_valid = 1'b0;
         bus.imem_rsp_data  = '0;
      end
      #1;
      samp_req_valid  = bus.imem_req_valid;
      samp_req_ready  = bus.imem_req_ready;
      samp_req_addr   = bus.imem_req_addr;
      samp_inst_valid = bus.inst_valid;
      if (bus.imem_rsp_valid) void'(mq.pop_front());
      if (bus.imem_req_valid && bus.imem_req_ready) begin
         mq.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
         hs_q.push_back(bus.imem_req_addr);
      end
      if (bus.inst_valid && bus.inst_ready) begin
         xpc_q.push_back(bus.inst_pc);
         xinst_q.push_back(bus.inst);
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_reset();
      rst                = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.imem_req_ready = 1'b1;
      bus.inst_ready     = 1'b1;
      step();
      step();
      mq.delete();
      clear_logs();
   endtask

   task automatic redirect_cycle(input logic [31:0] pc);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = pc;
      step();
      bus.redirect_valid = 1'b0;
   endtask

   initial begin
      rst                = 1'b1;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      @(negedge clk);

      // Reset state
      do_reset();
      #1;
      check_vec("rst_req_valid",  32'(bus.imem_req_valid), 32'd0);
      check_vec("rst_inst_valid", 32'(bus.inst_valid),     32'd0);
      check_vec("rst_req_addr",   bus.imem_req_addr,       32'h0);
      check_vec("rst_inst",       bus.inst,                32'h0);
      check_vec("rst_inst_pc",    bus.inst_pc,             32'h0);

      // Streaming, 1-cycle memory
      lat = 1;
      rst = 1'b0;
      #1;
      check_vec("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
      check_vec("first_req_addr",  bus.imem_req_addr,       32'h0);
      step();
      check_vec("lat_c0_inst_valid", 32'(samp_inst_valid), 32'd0);
      step();
      check_vec("lat_c1_inst_valid", 32'(samp_inst_valid), 32'd0);
      step();
      check_vec("lat_c2_inst_valid", 32'(samp_inst_valid), 32'd1);
      check_vec("lat_c2_inst_pc",    q_at(xpc_q, 0),       32'h0);
      repeat (20) step();
      for (int i = 0; i < 6; i++) begin
         check_vec("stream_req_addr", q_at(hs_q, i),    32'(4 * i));
         check_vec("stream_inst_pc",  q_at(xpc_q, i),   32'(4 * i));
         check_vec("stream_inst",     q_at(xinst_q, i), mem_word(32'(4 * i)));
      end
      check_vec("stream_count_ok", 32'(xpc_q.size() >= 10), 32'd1);

      // Decoder stalled: credit limit of two
      do_reset();
      rst            = 1'b0;
      bus.inst_ready = 1'b0;
      repeat (8) step();
      check_vec("stall_hs_count", 32'(hs_q.size()), 32'd2);
      check_vec("stall_hs0",      q_at(hs_q, 0),    32'h0);
      check_vec("stall_hs1",      q_at(hs_q, 1),    32'h4);
      check_vec("stall_req_valid", 32'(samp_req_valid), 32'd0);
      bus.inst_ready = 1'b1;
      clear_logs();
      repeat (10) step();
      check_vec("resume_hs0",  q_at(hs_q, 0),  32'h8);
      check_vec("resume_pc0",  q_at(xpc_q, 0), 32'h0);
      check_vec("resume_pc1",  q_at(xpc_q, 1), 32'h4);
      check_vec("resume_pc2",  q_at(xpc_q, 2), 32'h8);

      // Redirect with two requests outstanding
      do_reset();
      rst = 1'b0;
      lat = 3;
      redirect_cycle(32'h10);
      step();
      step();
      check_vec("pre_redir_hs0", q_at(hs_q, 0), 32'h10);
      check_vec("pre_redir_hs1", q_at(hs_q, 1), 32'h14);
      check_vec("pre_redir_xfers", 32'(xpc_q.size()), 32'd0);
      redirect_cycle(32'h103);
      clear_logs();
      repeat (15) step();
      check_vec("redir_hs0",   q_at(hs_q, 0),    32'h100);
      check_vec("redir_pc0",   q_at(xpc_q, 0),   32'h100);
      check_vec("redir_inst0", q_at(xinst_q, 0), mem_word(32'h100));
      check_vec("redir_pc1",   q_at(xpc_q, 1),   32'h104);

      // Redirect colliding with a response and a ready decoder
      do_reset();
      rst            = 1'b0;
      lat            = 1;
      bus.inst_ready = 1'b0;
      redirect_cycle(32'h1C);
      step();
      step();
      #1;
      check_vec("coll_buf_valid", 32'(bus.inst_valid), 32'd1);
      check_vec("coll_buf_pc",    bus.inst_pc,         32'h1C);
      check_vec("coll_hs1",       q_at(hs_q, 1),       32'h20);
      bus.inst_ready = 1'b1;
      redirect_cycle(32'h200);
      check_vec("coll_redir_inst_valid", 32'(samp_inst_valid), 32'd0);
      check_vec("coll_no_xfer", 32'(xpc_q.size()), 32'd0);
      #1;
      check_vec("coll_next_inst_valid", 32'(bus.inst_valid),     32'd0);
      check_vec("coll_next_req_valid",  32'(bus.imem_req_valid), 32'd1);
      check_vec("coll_next_req_addr",   bus.imem_req_addr,       32'h200);
      clear_logs();
      repeat (8) step();
      check_vec("coll_first_pc", q_at(xpc_q, 0), 32'h200);

      // Address wrap
      do_reset();
      rst = 1'b0;
      lat = 1;
      redirect_cycle(32'hFFFF_FFF8);
      clear_logs();
      repeat (12) step();
      check_vec("wrap_hs0", q_at(hs_q, 0),  32'hFFFF_FFF8);
      check_vec("wrap_hs1", q_at(hs_q, 1),  32'hFFFF_FFFC);
      check_vec("wrap_hs2", q_at(hs_q, 2),  32'h0000_0000);
      check_vec("wrap_pc0", q_at(xpc_q, 0), 32'hFFFF_FFF8);
      check_vec("wrap_pc1", q_at(xpc_q, 1), 32'hFFFF_FFFC);
      check_vec("wrap_pc2", q_at(xpc_q, 2), 32'h0000_0000);

      // Random stalls, 3-cycle memory
      do_reset();
      rst = 1'b0;
      lat = 3;
      redirect_cycle(32'h4000);
      clear_logs();
      for (int i = 0; i < 1000; i++) begin
         logic       prev_stall;
         logic [31:0] prev_addr;
         prev_stall         = samp_req_valid && !samp_req_ready;
         prev_addr          = samp_req_addr;
         bus.imem_req_ready = ($urandom_range(0, 3) != 0);
         bus.inst_ready     = ($urandom_range(0, 3) != 0);
         step();
         if (i > 0 && prev_stall) begin
            check_vec("rand_req_hold_valid", 32'(samp_req_valid), 32'd1);
            check_vec("rand_req_hold_addr",  samp_req_addr,       prev_addr);
         end
      end
      bus.imem_req_ready = 1'b1;
      bus.inst_ready     = 1'b1;
      repeat (10) step();
      check_vec("rand_xfer_count_ok", 32'(xpc_q.size() > 200), 32'd1);
      for (int i = 0; i < xpc_q.size(); i++) begin
         check_vec("rand_inst_pc", xpc_q[i],   32'h4000 + 32'(4 * i));
         check_vec("rand_inst",    xinst_q[i], mem_word(32'h4000 + 32'(4 * i)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/riscv_fetch.md
RISCV_FETCH -- requirements
Module: riscv_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter DEPTH, default 2, instruction buffer entries and maximum outstanding memory requests (legal range 1..8).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_addr  output  32  fetch byte address, bits [1:0] always 0.
REQ-007 imem_req_ready  input  1  memory accepts request; handshake = valid && ready.
REQ-008 imem_rsp_valid  input  1  response valid; in order, no backpressure, at least 1 cycle after request handshake.
REQ-009 imem_rsp_data  input  32  instruction word.
REQ-010 redirect_valid  input  1  single-cycle PC redirect (branch/jump/trap).
REQ-011 redirect_pc  input  32  new fetch address; bits [1:0] ignored, treated as 0.
REQ-012 inst_valid  output  1  instruction available to the decoder.
REQ-013 inst  output  32  instruction word presented to the decoder.
REQ-014 inst_pc  output  32  address of inst.
REQ-015 inst_ready  input  1  decoder accepts; transfer = inst_valid && inst_ready.

Function
REQ-016 Fetch PC register SHALL advance by 4 on each request handshake, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-017 imem_req_addr SHALL equal the fetch PC register; imem_req_valid SHALL be high iff not in reset, redirect_valid is low, and (outstanding + buffer occupancy) < DEPTH.
REQ-018 imem_req_valid, once high, SHALL hold with a stable address until handshake or a redirect.
REQ-019 Outstanding counter SHALL increment on request handshake and decrement on imem_rsp_valid; simultaneous events leave it unchanged.
REQ-020 A drop counter SHALL count responses belonging to a flushed stream; while nonzero, each imem_rsp_valid decrements it and the response is discarded.
REQ-021 Non-discarded responses SHALL be pushed into the buffer tagged with a response-PC register, which then increments by 4 (same wrap as REQ-016).
REQ-022 inst_valid SHALL be (buffer not empty) && !redirect_valid; inst/inst_pc SHALL be the buffer head; a transfer pops the head.
REQ-023 Push and pop in the same cycle SHALL both take effect, occupancy unchanged; push into an empty buffer is visible on inst_valid the next cycle (1-cycle response-to-decode latency).
REQ-024 On redirect_valid: next cycle fetch PC and response PC = {redirect_pc[31:2],2'b00}; buffer emptied; drop counter = outstanding after this cycle's updates (REQ-019), so this cycle's response is discarded.
REQ-025 A redirect arriving while the drop counter is nonzero SHALL replace it with the REQ-024 value, never add.
REQ-026 imem_rsp_valid with outstanding = 0 SHALL be ignored and counters unchanged (protocol error; bench asserts it never happens).
REQ-027 The credit rule SHALL guarantee a push never hits a full buffer; overflow is unreachable and asserted in simulation.

Reset
REQ-028 While rst is high: imem_req_valid=0, inst_valid=0, fetch PC=response PC=RESET_PC, outstanding=0, drop=0, buffer empty; imem_req_addr=RESET_PC, inst and inst_pc=0.
REQ-029 rst asserted mid-operation SHALL abandon all in-flight requests; responses arriving during or after reset for pre-reset requests are the memory's responsibility to suppress.
REQ-030 The first request (addr RESET_PC) SHALL be presented in the first cycle after rst deasserts.

Structure
REQ-031 RESET_PC default, PC increment (4) and the instruction width SHALL live in the shared riscv_defs package.
REQ-032 The buffer SHALL be a sub-module riscv_fetch_fifo (DEPTH entries of {pc,inst}, push/pop/flush, empty/count outputs); counters sized to $clog2(DEPTH+1) bits.

Verification
REQ-033 Reset, imem_req_ready=1, 1-cycle memory, inst_ready=1 -> requests 0x0,0x4,0x8...; inst_pc 0x0 appears on inst_valid 2 cycles after first handshake, then one instruction per cycle.
REQ-034 inst_ready=0 throughout -> exactly DEPTH=2 handshakes (0x0,0x4), then imem_req_valid stays 0; raising inst_ready resumes at 0x8.
REQ-035 Two requests outstanding (0x10,0x14), redirect_pc=0x103 -> next request addr 0x100; both old responses discarded; first inst_pc seen = 0x100.
REQ-036 Redirect in same cycle as response for 0x20 and inst transfer of 0x1C -> 0x20 discarded, buffer empty next cycle, inst_valid low during redirect cycle.
REQ-037 Redirect to 0xFFFF_FFF8 -> fetch addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 with matching inst_pc values.
REQ-038 Random imem_req_ready/inst_ready stalls, 3-cycle memory latency, 1000 cycles -> inst_pc sequence strictly +4, no drops or duplicates, overflow assertion never fires.
